// File: rtl/add_np.sv
`default_nettype none
// add_np: WIDTH-bit adder/subtractor whose carry chain is cut into STAGES registered chunks under a valid/ready handshake.
// Revision 1.0
module add_np #(
  parameter int WIDTH  = 15,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = (WIDTH + STAGES - 1) / STAGES;

  logic w_adv;

  assign in_ready = !(out_valid && !out_ready);
  assign w_adv    = in_ready;

  // Stage k adds chunk k. Unconsumed operand bits ride along (skew) and
  // finished low chunks accumulate in r_s (deskew), so one operation
  // always occupies exactly one stage slot.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CW;
    localparam int HI = (k == STAGES - 1) ? WIDTH : (k + 1) * CW;
    localparam int NW = HI - LO;
    localparam int RW = WIDTH - HI;

    logic [WIDTH-LO-1:0] w_xin;
    logic [WIDTH-LO-1:0] w_yin;
    logic                w_ci;
    logic                w_vi;
    logic                w_sub;
    logic                w_co;
    logic [NW-1:0]       w_yc;
    logic [NW-1:0]       w_sc;
    logic [HI-1:0]       w_s;
    logic [HI-1:0]       r_s;
    logic                r_c;
    logic                r_v;

    if (k == 0) begin : g_first
      assign w_xin = X;
      assign w_yin = Y;
      assign w_ci  = sub | cin;
      assign w_vi  = in_valid;
      assign w_sub = sub;
      assign w_s   = w_sc;
    end else begin : g_next
      assign w_xin = g_stage[k-1].g_rem.r_x;
      assign w_yin = g_stage[k-1].g_rem.r_y;
      assign w_ci  = g_stage[k-1].r_c;
      assign w_vi  = g_stage[k-1].r_v;
      assign w_sub = g_stage[k-1].g_rem.r_sub;
      assign w_s   = {w_sc, g_stage[k-1].r_s};
    end

    // Each Y chunk is inverted as it enters its stage, steered by the sub
    // bit that travels with the operation.
    assign w_yc = w_sub ? ~w_yin[NW-1:0] : w_yin[NW-1:0];
    assign {w_co, w_sc} = {1'b0, w_xin[NW-1:0]} + {1'b0, w_yc} + (NW+1)'(w_ci);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_s <= w_s;
        r_c <= w_co;
        r_v <= w_vi;
      end
    end

    if (RW > 0) begin : g_rem
      logic [RW-1:0] r_x;
      logic [RW-1:0] r_y;
      logic          r_sub;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_x   <= '0;
          r_y   <= '0;
          r_sub <= 1'b0;
        end else if (w_adv) begin
          r_x   <= w_xin[WIDTH-LO-1:NW];
          r_y   <= w_yin[WIDTH-LO-1:NW];
          r_sub <= w_sub;
        end
      end
    end
  end

  assign sum       = g_stage[STAGES-1].r_s;
  assign cout      = g_stage[STAGES-1].r_c;
  assign out_valid = g_stage[STAGES-1].r_v;

endmodule
`default_nettype wire

// File: tb/tb_add_np.sv
`default_nettype none
// tb_add_np: scoreboard bench for add_np at STAGES=3 (randomized, stalled) and STAGES=1/15 (directed).
// Revision 1.0
module tb_add_np;
  typedef struct {
    logic [14:0] s;
    logic        c;
    int          tag;
  } exp_t;

  localparam int STG [3] = '{3, 1, 15};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv0 = 1'b0, c0 = 1'b0, s0 = 1'b0, or0 = 1'b1;
  logic iv1 = 1'b0, c1 = 1'b0, s1 = 1'b0;
  logic [14:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic rand_or = 1'b0;

  logic [2:0]       ir, ov, co, iva, ca, sa, ordy;
  logic [2:0][14:0] sm, xa, ya;

  assign iva  = {iv1, iv1, iv0};
  assign ca   = {c1, c1, c0};
  assign sa   = {s1, s1, s0};
  assign xa   = {x1, x1, x0};
  assign ya   = {y1, y1, y0};
  assign ordy = {1'b1, 1'b1, or0};

  add_np #(.WIDTH(15), .STAGES(3)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir[0]), .X(x0), .Y(y0), .cin(c0), .sub(s0),
    .sum(sm[0]), .cout(co[0]), .out_valid(ov[0]), .out_ready(or0));
  add_np #(.WIDTH(15), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir[1]), .X(x1), .Y(y1), .cin(c1), .sub(s1),
    .sum(sm[1]), .cout(co[1]), .out_valid(ov[1]), .out_ready(1'b1));
  add_np #(.WIDTH(15), .STAGES(15)) u_s15 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir[2]), .X(x1), .Y(y1), .cin(c1), .sub(s1),
    .sum(sm[2]), .cout(co[2]), .out_valid(ov[2]), .out_ready(1'b1));

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q [3][$];
  int   adv [3] = '{0, 0, 0};
  logic held [3] = '{1'b0, 1'b0, 1'b0};
  exp_t me;

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [dut%0d]: got %0d, expected %0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, modulo 2^15.
  function automatic exp_t model(input logic [14:0] x, input logic [14:0] y,
                                 input logic c, input logic s, input int tag);
    exp_t e;
    int   full;
    full  = s ? (int'(x) + 32768 - int'(y)) : (int'(x) + int'(y) + int'(c));
    e.s   = 15'(full % 32768);
    e.c   = (full >= 32768);
    e.tag = tag;
    return e;
  endfunction

  // Monitor: checks what the DUT shows now, then records what the next edge captures.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        q[i].delete();
        held[i] = 1'b0;
        chk("rst_out_valid", i, ov[i], 0);
        chk("rst_in_ready", i, ir[i], 1);
        chk("rst_sum", i, sm[i], 0);
        chk("rst_cout", i, co[i], 0);
      end else begin
        if (ov[i]) begin
          chk("result_expected", i, int'(q[i].size() > 0), 1);
          if (q[i].size() > 0) begin
            me = q[i][0];
            if (!held[i]) chk("latency_adv_edges", i, adv[i], me.tag);
            chk("sum", i, sm[i], me.s);
            chk("cout", i, co[i], me.c);
            if (ordy[i]) void'(q[i].pop_front());
          end
        end
        held[i] = ov[i] && !ordy[i];
        if (iva[i] && ir[i]) q[i].push_back(model(xa[i], ya[i], ca[i], sa[i], adv[i] + STG[i]));
        if (ir[i]) adv[i]++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    or0 = rand_or ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic idle(input int n);
    iv0 = 1'b0;
    iv1 = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue0(input logic [14:0] x, input logic [14:0] y, input logic c, input logic s);
    logic a;
    a   = 1'b0;
    iv0 = 1'b1; x0 = x; y0 = y; c0 = c; s0 = s;
    for (int t = 0; t < 500 && !a; t++) begin
      @(negedge clk);
      a = ir[0];
      @(posedge clk);
      #1;
    end
    chk("accepted", 0, a, 1);
    iv0 = 1'b0;
  endtask

  task automatic issue1(input logic [14:0] x, input logic [14:0] y, input logic c, input logic s);
    logic a;
    a   = 1'b0;
    iv1 = 1'b1; x1 = x; y1 = y; c1 = c; s1 = s;
    for (int t = 0; t < 500 && !a; t++) begin
      @(negedge clk);
      a = ir[1] && ir[2];
      @(posedge clk);
      #1;
    end
    chk("accepted", 1, a, 1);
    iv1 = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && (q[0].size() + q[1].size() + q[2].size()) > 0; t++) @(negedge clk);
    chk("drained", 0, q[0].size() + q[1].size() + q[2].size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue0(15'd10, 15'd0, 1'b0, 1'b0);
    idle(4);
    issue0(15'd2002, 15'd2002, 1'b0, 1'b0);
    issue0(15'd32767, 15'd1, 1'b0, 1'b0);
    idle(4);
    issue0(15'd5, 15'd7, 1'b1, 1'b1);
    issue0(15'd7, 15'd5, 1'b0, 1'b1);
    issue0(15'd32767, 15'd32767, 1'b1, 1'b0);
    issue0(15'd0, 15'd0, 1'b1, 1'b1);
    idle(4);

    issue1(15'd10, 15'd0, 1'b0, 1'b0);
    idle(2);
    issue1(15'd2002, 15'd2002, 1'b0, 1'b0);
    issue1(15'd32767, 15'd1, 1'b0, 1'b0);
    issue1(15'd5, 15'd7, 1'b0, 1'b1);
    drain();

    rand_or = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue0(15'($urandom), 15'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_or = 1'b0;
    drain();

    // Reset with two ops in flight and a third presented during reset.
    issue0(15'd100, 15'd200, 1'b0, 1'b0);
    issue0(15'd300, 15'd400, 1'b1, 1'b0);
    iv0 = 1'b1; x0 = 15'd500; y0 = 15'd600;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    iv0 = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 0, ov[0], 0);
      chk("post_rst_in_ready", 0, ir[0], 1);
    end
    issue0(15'd1234, 15'd4321, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
